// File: rtl/nfc_atom_data_in_if.sv
// -----------------------------------------------------------------------------
// nfc_atom_data_in_if
//
// Upstream read-data stream of the NAND data-in atom. The atom is the master
// (it produces the captured words). The consumer is the slave.
//   oReadData  : FIFO head word (master -> slave)
//   oReadValid : FIFO not empty (master -> slave)
//   iReadReady : consumer accepts the head word this cycle (slave -> master)
// -----------------------------------------------------------------------------
interface nfc_atom_data_in_if;
  logic [31:0] oReadData;
  logic        oReadValid;
  logic        iReadReady;

  modport master (output oReadData, output oReadValid, input iReadReady);
  modport slave  (input oReadData, input oReadValid, output iReadReady);
endinterface

// File: rtl/nfc_atom_data_in.sv
// -----------------------------------------------------------------------------
// nfc_atom_data_in
//
// Read-path data-in atom of the NAND flash controller. The read command and
// address sequence has already been issued when this atom starts. The atom
// then toggles RE toward the selected way. It captures the 32-bit words that
// the PHY returns and buffers them in a FIFO for the upstream data stream.
// RE toggling is limited by credit, so the FIFO can never overflow. Downstream
// back-pressure therefore throttles the NAND burst.
//
// Ports
//   iSystemClock, iReset      : clock, synchronous active-high reset
//   iStart/iTargetWay/iNumOfData : start pulse, one-hot way, burst length
//                               (the way and the length are latched in IDLE)
//   oReady, oLastStep         : idle indication, one-cycle completion pulse
//   iDQ, iDQValid             : captured word from the PHY
//   rd (master modport)       : oReadData / oReadValid / iReadReady stream
//   oChipEnable, oReadEnable  : CE (2 bits per way) and RE phase pattern
//   oDQ*, oWriteEnable, oAddressLatchEnable, oCommandLatchEnable : held 0
//   oTimeout                  : sticky watchdog flag
//
// Optional feature: define NFC_DATAIN_WATCHDOG_EN to enable the WAIT-state
// watchdog. When the macro is undefined, WAIT waits forever and oTimeout is 0.
// -----------------------------------------------------------------------------
module nfc_atom_data_in #(
  parameter int NumberOfWays    = 4,
  parameter int FifoDepth       = 16,
  parameter int PreambleCycles  = 4,
  parameter int PostambleCycles = 4,
  parameter int WatchdogCycles  = 255
) (
  input  logic                      iSystemClock,
  input  logic                      iReset,
  input  logic                      iStart,
  input  logic [NumberOfWays-1:0]   iTargetWay,
  input  logic [15:0]               iNumOfData,
  output logic                      oReady,
  output logic                      oLastStep,
  input  logic [31:0]               iDQ,
  input  logic                      iDQValid,
  nfc_atom_data_in_if.master        rd,
  output logic                      oDQSOutEnable,
  output logic                      oDQOutEnable,
  output logic [7:0]                oDQStrobe,
  output logic [31:0]               oDQ,
  output logic [2*NumberOfWays-1:0] oChipEnable,
  output logic [3:0]                oReadEnable,
  output logic [3:0]                oWriteEnable,
  output logic [3:0]                oAddressLatchEnable,
  output logic [3:0]                oCommandLatchEnable,
  output logic                      oTimeout
);

  localparam int AW = $clog2(FifoDepth);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_TOGGLE, S_WAIT, S_POSTAMBLE, S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [NumberOfWays-1:0] way_q, way_d;
  logic [15:0]             len_q, len_d;
  logic [15:0]             issued_q, issued_d;
  logic [15:0]             received_q, received_d;
  logic [15:0]             phase_q, phase_d;
  logic [CW-1:0]           credit_q, credit_d;
  logic [CW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [31:0]             mem_q [FifoDepth];

`ifdef NFC_DATAIN_WATCHDOG_EN
  logic [15:0]             wd_q, wd_d;
  logic                    timeout_q, timeout_d;
`endif

  logic fifo_empty, fifo_full, capture_window, push, pop, can_issue, issue;

  always_comb begin
    fifo_empty     = (wr_ptr_q == rd_ptr_q);
    fifo_full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // Words are accepted only while a burst is in flight. Stray valids in
    // IDLE or DONE are ignored.
    capture_window = (state_q == S_PREAMBLE) || (state_q == S_TOGGLE) ||
                     (state_q == S_WAIT)     || (state_q == S_POSTAMBLE);
    push           = iDQValid && capture_window && !fifo_full;
    pop            = !fifo_empty && rd.iReadReady;
    // Credit counts words issued but not yet popped. This counts words still
    // in the PHY pipeline as well as words held in the FIFO.
    can_issue      = (credit_q < CW'(FifoDepth)) && (issued_q < len_q);
    issue          = (state_q == S_TOGGLE) && can_issue;
  end

  always_comb begin
    state_d    = state_q;
    way_d      = way_q;
    len_d      = len_q;
    issued_d   = issued_q;
    phase_d    = phase_q;
    received_d = received_q + 16'(iDQValid && capture_window);
    credit_d   = credit_q + CW'(issue) - CW'(pop);
    wr_ptr_d   = wr_ptr_q + CW'(push);
    rd_ptr_d   = rd_ptr_q + CW'(pop);
`ifdef NFC_DATAIN_WATCHDOG_EN
    wd_d       = '0;
    timeout_d  = timeout_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          way_d      = iTargetWay;
          len_d      = iNumOfData;
          issued_d   = '0;
          received_d = '0;
          phase_d    = '0;
          credit_d   = '0;
`ifdef NFC_DATAIN_WATCHDOG_EN
          timeout_d  = 1'b0;
`endif
          state_d    = (iNumOfData == 16'd0) ? S_DONE : S_PREAMBLE;
        end
      end
      S_PREAMBLE: begin
        if (phase_q == 16'(PreambleCycles - 1)) begin
          phase_d = '0;
          state_d = S_TOGGLE;
        end else begin
          phase_d = phase_q + 16'd1;
        end
      end
      S_TOGGLE: begin
        if (issue) begin
          issued_d = issued_q + 16'd1;
          if (issued_q + 16'd1 == len_q) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (received_q == len_q) begin
          phase_d = '0;
          state_d = S_POSTAMBLE;
        end
`ifdef NFC_DATAIN_WATCHDOG_EN
        else if (iDQValid) begin
          wd_d = '0;
        end else if (wd_q == 16'(WatchdogCycles - 1)) begin
          timeout_d = 1'b1;
          phase_d   = '0;
          state_d   = S_POSTAMBLE;
        end else begin
          wd_d = wd_q + 16'd1;
        end
`endif
      end
      S_POSTAMBLE: begin
        if (phase_q == 16'(PostambleCycles - 1)) begin
          phase_d = '0;
          state_d = S_DONE;
        end else begin
          phase_d = phase_q + 16'd1;
        end
      end
      S_DONE: begin
        if (fifo_empty) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iSystemClock) begin
    if (iReset) begin
      state_q    <= S_IDLE;
      way_q      <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      received_q <= '0;
      phase_q    <= '0;
      credit_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
`ifdef NFC_DATAIN_WATCHDOG_EN
      wd_q       <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      way_q      <= way_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      received_q <= received_d;
      phase_q    <= phase_d;
      credit_q   <= credit_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
`ifdef NFC_DATAIN_WATCHDOG_EN
      wd_q       <= wd_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  // The storage array is not reset. Its contents are meaningful only between
  // the pointers, and the pointers are reset.
  always_ff @(posedge iSystemClock) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= iDQ;
  end

  assign rd.oReadData  = mem_q[rd_ptr_q[AW-1:0]];
  assign rd.oReadValid = !fifo_empty;

`ifdef NFC_DATAIN_WATCHDOG_EN
  assign oTimeout = timeout_q;
`else
  logic unused_wd_cfg;
  assign unused_wd_cfg = (WatchdogCycles != 0);
  assign oTimeout      = 1'b0;
`endif

  // Pin bundle: the pins are decoded from the registered state. The DQ pins
  // are inputs for this atom, so every output enable stays low.
  always_comb begin
    oReady              = (state_q == S_IDLE);
    oLastStep           = (state_q == S_DONE) && fifo_empty;
    oDQSOutEnable       = 1'b0;
    oDQOutEnable        = 1'b0;
    oDQStrobe           = '0;
    oDQ                 = '0;
    oWriteEnable        = '0;
    oAddressLatchEnable = '0;
    oCommandLatchEnable = '0;
    for (int i = 0; i < NumberOfWays; i++) begin
      oChipEnable[2*i +: 2] = {2{capture_window & way_q[i]}};
    end
    case (state_q)
      S_PREAMBLE: oReadEnable = 4'b0000;
      S_TOGGLE:   oReadEnable = issue ? 4'b0101 : 4'b1111;
      default:    oReadEnable = 4'b1111;
    endcase
  end

endmodule

// File: tb/tb_nfc_atom_data_in.sv
module tb_nfc_atom_data_in;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        iReset = 1'b1;
  logic        iStart = 1'b0;
  logic [3:0]  iTargetWay = '0;
  logic [15:0] iNumOfData = '0;
  logic [31:0] iDQ = '0;
  logic        iDQValid = 1'b0;
  logic        oReady, oLastStep, oDQSOutEnable, oDQOutEnable, oTimeout;
  logic [7:0]  oDQStrobe, oChipEnable;
  logic [31:0] oDQ;
  logic [3:0]  oReadEnable, oWriteEnable, oAddressLatchEnable, oCommandLatchEnable;

  nfc_atom_data_in_if rd_if();

  nfc_atom_data_in dut (
    .iSystemClock(clk), .iReset(iReset), .iStart(iStart),
    .iTargetWay(iTargetWay), .iNumOfData(iNumOfData),
    .oReady(oReady), .oLastStep(oLastStep),
    .iDQ(iDQ), .iDQValid(iDQValid), .rd(rd_if),
    .oDQSOutEnable(oDQSOutEnable), .oDQOutEnable(oDQOutEnable),
    .oDQStrobe(oDQStrobe), .oDQ(oDQ), .oChipEnable(oChipEnable),
    .oReadEnable(oReadEnable), .oWriteEnable(oWriteEnable),
    .oAddressLatchEnable(oAddressLatchEnable),
    .oCommandLatchEnable(oCommandLatchEnable), .oTimeout(oTimeout)
  );

  int errors = 0;
  int checks = 0;

  // Monitor and PHY model state.
  int          n_toggle, n_got, n_last, phy_idx;
  logic [7:0]  ce_seen;
  logic [31:0] got [64];
  logic [2:0]  phy_pipe = '0;

  function automatic logic [31:0] tb_word(input int idx);
    if (idx < 8) return 32'h11111111 * 32'(idx + 1);
    return 32'hC0DE0000 + 32'(idx);
  endfunction

  // PHY returns a word three clocks after each RE toggle. The monitor also
  // records popped words, the toggles, the CE bits and the completion pulses.
  initial begin
    rd_if.iReadReady = 1'b0;
    forever begin
      @(negedge clk);
      if (oReadEnable == 4'b0101) n_toggle++;
      if (oLastStep) n_last++;
      ce_seen = ce_seen | oChipEnable;
      if (rd_if.oReadValid && rd_if.iReadReady && n_got < 64) begin
        got[n_got] = rd_if.oReadData;
        n_got++;
      end
      phy_pipe = {phy_pipe[1:0], (oReadEnable == 4'b0101)};
      if (phy_pipe[2]) begin
        iDQValid = 1'b1;
        iDQ      = tb_word(phy_idx);
        phy_idx++;
      end else begin
        iDQValid = 1'b0;
        iDQ      = '0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 300000");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    n_toggle = 0; n_got = 0; n_last = 0; phy_idx = 0; ce_seen = '0;
  endtask

  task automatic test_reset();
    iReset = 1'b1;
    repeat (3) tick();
    iReset = 1'b0;
    checks++; if (oReady !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", oReady); end
    checks++; if (oLastStep !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", oLastStep); end
    checks++; if (rd_if.oReadValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rd_if.oReadValid); end
    checks++; if (oChipEnable !== 8'h00) begin errors++; $display("FAIL reset_ce: got %h want 00", oChipEnable); end
    checks++; if (oReadEnable !== 4'b1111) begin errors++; $display("FAIL reset_re: got %b want 1111", oReadEnable); end
    checks++; if (oTimeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", oTimeout); end
    checks++;
    if ({oDQSOutEnable, oDQOutEnable, oDQStrobe, oDQ, oWriteEnable, oAddressLatchEnable, oCommandLatchEnable} !== '0) begin
      errors++; $display("FAIL reset_pins: got nonzero pins want all 0");
    end
  endtask

  task automatic test_burst8();
    int bad = 0;
    bit done = 0;
    clear_mon();
    rd_if.iReadReady = 1'b1;
    iTargetWay = 4'b0100; iNumOfData = 16'd8; iStart = 1'b1;
    tick();
    iStart = 1'b0;
    checks++; if (oReady !== 1'b0) begin errors++; $display("FAIL b8_busy: got %b want 0", oReady); end
    checks++; if (oChipEnable !== 8'b0011_0000) begin errors++; $display("FAIL b8_ce: got %b want 00110000", oChipEnable); end
    checks++; if (oReadEnable !== 4'b0000) begin errors++; $display("FAIL b8_pre: got %b want 0000", oReadEnable); end
    for (int k = 2; k <= 13; k++) begin
      tick();
      if (k < 5 && oReadEnable !== 4'b0000) bad++;
      if (k >= 5 && k <= 12 && oReadEnable !== 4'b0101) bad++;
      if (k == 13 && oReadEnable !== 4'b1111) bad++;
      if (k == 7) begin
        checks++; if (rd_if.oReadValid !== 1'b0) begin errors++; $display("FAIL b8_early_valid: got %b want 0", rd_if.oReadValid); end
      end
      if (k == 8) begin
        checks++;
        if (rd_if.oReadValid !== 1'b1 || rd_if.oReadData !== 32'h11111111) begin
          errors++; $display("FAIL b8_first_word: got v=%b d=%h want v=1 d=11111111", rd_if.oReadValid, rd_if.oReadData);
        end
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL b8_re_timeline: got %0d wrong RE cycles want 0", bad); end
    for (int c = 0; c < 200 && !done; c++) begin
      tick();
      if (oLastStep === 1'b1) done = 1;
    end
    checks++; if (!done) begin errors++; $display("FAIL b8_done_wait: got no oLastStep want pulse within 200 clocks"); end
    repeat (2) tick();
    bad = 0;
    for (int i = 0; i < 8; i++) if (got[i] !== tb_word(i)) bad++;
    checks++; if (n_toggle != 8) begin errors++; $display("FAIL b8_toggles: got %0d want 8", n_toggle); end
    checks++; if (n_got != 8 || bad != 0) begin errors++; $display("FAIL b8_words: got %0d words %0d wrong want 8 words 0 wrong", n_got, bad); end
    checks++; if (ce_seen !== 8'b0011_0000) begin errors++; $display("FAIL b8_ce_only: got %b want 00110000", ce_seen); end
    checks++; if (n_last != 1) begin errors++; $display("FAIL b8_laststep: got %0d want 1", n_last); end
    checks++; if (oReady !== 1'b1) begin errors++; $display("FAIL b8_ready: got %b want 1", oReady); end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    bit done = 0;
    clear_mon();
    rd_if.iReadReady = 1'b0;
    iTargetWay = 4'b0001; iNumOfData = 16'd40; iStart = 1'b1;
    tick();
    iStart = 1'b0;
    repeat (60) tick();
    checks++; if (n_toggle != 16) begin errors++; $display("FAIL bp_toggles_stalled: got %0d want 16", n_toggle); end
    checks++; if (oReadEnable !== 4'b1111) begin errors++; $display("FAIL bp_pause_re: got %b want 1111", oReadEnable); end
    checks++; if (oReady !== 1'b0 || n_got != 0) begin errors++; $display("FAIL bp_held: got ready=%b popped=%0d want 0 0", oReady, n_got); end
    checks++; if (rd_if.oReadValid !== 1'b1 || rd_if.oReadData !== 32'h11111111) begin
      errors++; $display("FAIL bp_head: got v=%b d=%h want v=1 d=11111111", rd_if.oReadValid, rd_if.oReadData);
    end
    rd_if.iReadReady = 1'b1;
    for (int c = 0; c < 600 && !done; c++) begin
      tick();
      if (oLastStep === 1'b1) done = 1;
    end
    checks++; if (!done) begin errors++; $display("FAIL bp_done_wait: got no oLastStep want pulse within 600 clocks"); end
    repeat (2) tick();
    for (int i = 0; i < 40; i++) if (got[i] !== tb_word(i)) bad++;
    checks++; if (n_toggle != 40) begin errors++; $display("FAIL bp_toggles_total: got %0d want 40", n_toggle); end
    checks++; if (n_got != 40 || bad != 0) begin errors++; $display("FAIL bp_words: got %0d words %0d wrong want 40 words 0 wrong", n_got, bad); end
    checks++; if (n_last != 1) begin errors++; $display("FAIL bp_laststep: got %0d want 1", n_last); end
  endtask

  task automatic test_zero_len();
    clear_mon();
    iTargetWay = 4'b0010; iNumOfData = 16'd0; iStart = 1'b1;
    tick();
    iStart = 1'b0;
    checks++; if (oLastStep !== 1'b1 || oReady !== 1'b0) begin
      errors++; $display("FAIL zl_done: got last=%b ready=%b want 1 0", oLastStep, oReady);
    end
    checks++; if (oChipEnable !== 8'h00) begin errors++; $display("FAIL zl_ce_done: got %h want 00", oChipEnable); end
    tick();
    checks++; if (oReady !== 1'b1 || oLastStep !== 1'b0) begin
      errors++; $display("FAIL zl_idle: got ready=%b last=%b want 1 0", oReady, oLastStep);
    end
    tick();
    checks++; if (n_toggle != 0 || ce_seen !== 8'h00) begin
      errors++; $display("FAIL zl_no_activity: got toggles=%0d ce=%h want 0 00", n_toggle, ce_seen);
    end
  endtask

  task automatic test_abort();
    bit hit = 0;
    clear_mon();
    rd_if.iReadReady = 1'b1;
    iTargetWay = 4'b1000; iNumOfData = 16'd20; iStart = 1'b1;
    tick();
    iStart = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      tick();
      if (n_toggle >= 5) hit = 1;
    end
    checks++; if (!hit) begin errors++; $display("FAIL ab_reach: got %0d toggles want 5 within 100 clocks", n_toggle); end
    checks++; if (oReadEnable !== 4'b0101 || oChipEnable !== 8'b1100_0000) begin
      errors++; $display("FAIL ab_midburst: got re=%b ce=%b want 0101 11000000", oReadEnable, oChipEnable);
    end
    iReset = 1'b1;
    tick();
    iReset = 1'b0;
    checks++; if (oChipEnable !== 8'h00 || oReadEnable !== 4'b1111) begin
      errors++; $display("FAIL ab_pins: got ce=%h re=%b want 00 1111", oChipEnable, oReadEnable);
    end
    checks++; if (rd_if.oReadValid !== 1'b0 || oReady !== 1'b1) begin
      errors++; $display("FAIL ab_state: got valid=%b ready=%b want 0 1", rd_if.oReadValid, oReady);
    end
    repeat (6) tick();
    checks++; if (rd_if.oReadValid !== 1'b0) begin errors++; $display("FAIL ab_idle_ignore: got %b want 0", rd_if.oReadValid); end
  endtask

  task automatic test_start_ignored();
    int bad = 0;
    bit done = 0;
    clear_mon();
    rd_if.iReadReady = 1'b1;
    iTargetWay = 4'b0010; iNumOfData = 16'd6; iStart = 1'b1;
    tick();
    iStart = 1'b0;
    repeat (5) tick();
    iTargetWay = 4'b0001; iNumOfData = 16'd12; iStart = 1'b1;
    tick();
    iStart = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      tick();
      if (oLastStep === 1'b1) done = 1;
    end
    checks++; if (!done) begin errors++; $display("FAIL si_done_wait: got no oLastStep want pulse within 200 clocks"); end
    repeat (2) tick();
    for (int i = 0; i < 6; i++) if (got[i] !== tb_word(i)) bad++;
    checks++; if (n_toggle != 6) begin errors++; $display("FAIL si_toggles: got %0d want 6", n_toggle); end
    checks++; if (n_got != 6 || bad != 0) begin errors++; $display("FAIL si_words: got %0d words %0d wrong want 6 words 0 wrong", n_got, bad); end
    checks++; if (ce_seen !== 8'b0000_1100) begin errors++; $display("FAIL si_ce: got %b want 00001100", ce_seen); end
    checks++; if (n_last != 1 || oReady !== 1'b1) begin errors++; $display("FAIL si_finish: got last=%0d ready=%b want 1 1", n_last, oReady); end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_burst8();
    test_backpressure();
    test_zero_len();
    test_abort();
    test_start_ignored();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nfc_atom_data_in.md
# nfc_atom_data_in

Read-path data-in atom of the NAND flash controller: after a read command/address sequence has been issued, it toggles RE toward the selected way, captures the 32-bit words returned by the PHY, and buffers them in an internal FIFO for the upstream data stream. It is the receiving counterpart of the pin-driving command/idle atoms and plugs into the same PHY output mux, driving the same pin bundle. RE toggling is credit-limited so the FIFO never overflows, and downstream back-pressure throttles the NAND burst.

## Interface
- NumberOfWays, 4, number of NAND ways (2 CE bits per way)
- FifoDepth, 16, capture FIFO depth in 32-bit words (power of two, ≥4)
- PreambleCycles, 4, RE-low preamble length in clocks (≥1)
- PostambleCycles, 4, RE-high postamble length in clocks (≥1)
- WatchdogCycles, 255, idle-capture timeout (used only with NFC_DATAIN_WATCHDOG_EN)
- iSystemClock  in  1  sole clock
- iReset  in  1  synchronous, active-high reset
- iStart  in  1  start pulse; sampled only in IDLE
- iTargetWay  in  NumberOfWays  one-hot way select, latched on start
- iNumOfData  in  16  burst length in 32-bit words, latched on start
- oReady  out  1  high only in IDLE
- oLastStep  out  1  one-cycle completion pulse
- iDQ  in  32  captured data word from PHY
- iDQValid  in  1  iDQ valid this cycle
- oReadData  out  32  FIFO head
- oReadValid  out  1  FIFO not empty
- iReadReady  in  1  pop when oReadValid && iReadReady
- oDQSOutEnable, oDQOutEnable  out  1 each  always 0 (pins are inputs)
- oDQStrobe  out  8  always 0;  oDQ  out  32  always 0
- oChipEnable  out  2*NumberOfWays  both bits of the selected way high while active
- oReadEnable  out  4  RE phase pattern
- oWriteEnable, oAddressLatchEnable, oCommandLatchEnable  out  4 each  always 0
- oTimeout  out  1  sticky watchdog flag; tied 0 without NFC_DATAIN_WATCHDOG_EN

## Operation
- States: IDLE, PREAMBLE, TOGGLE, WAIT, POSTAMBLE, DONE. All pin outputs are decoded from the registered state.
- IDLE: CE all 0, oReadEnable=4'b1111. When iStart is high, latch way and length. If the length is 0, go to DONE with CE never asserted. Otherwise go to PREAMBLE.
- PREAMBLE: CE asserted, oReadEnable=4'b0000 for PreambleCycles clocks, then TOGGLE.
- TOGGLE: credit = words issued − words popped. Each clock with credit<FifoDepth and issued<length:
  - oReadEnable=4'b0101 (one word);
  - issued count increments.
  
  Otherwise the clock is a pause with oReadEnable=4'b1111. After the final word is issued, go to WAIT.
- WAIT: RE=4'b1111; stay until received count (iDQValid pulses) == length, then POSTAMBLE.
- POSTAMBLE: RE=4'b1111, CE asserted, PostambleCycles clocks, then DONE.
- DONE: CE deasserted; hold until the FIFO is empty. oLastStep is high on the single cycle where state==DONE and the FIFO is empty; the next state is IDLE.
- FIFO behaviour:
  - iDQValid pushes iDQ;
  - a simultaneous push and pop is legal and leaves the occupancy unchanged;
  - a push while full cannot occur under credit control, and the word is dropped if it does;
  - iDQValid in IDLE/DONE is ignored.
- Counters are 16-bit; the credit counter is log2(FifoDepth)+1 bits and never wraps.
- Reset:
  - clears state to IDLE, counters, FIFO pointers and oTimeout;
  - takes effect the cycle after assertion;
  - mid-burst it aborts immediately without postamble and drops CE.

## Timing
- Reset values: oReady=1, oLastStep=0, oReadValid=0, CE=0, oReadEnable=4'b1111, oTimeout=0, all other pins 0.
- Start sampled at edge N → PREAMBLE from N+1; first 4'b0101 at N+1+PreambleCycles.
- Unthrottled burst of L words: TOGGLE lasts exactly L clocks.
- A pushed word is visible on oReadData the clock after the push.
- A zero-length start reaches DONE at N+1, with oLastStep at N+1 and oReady again at N+2.
- iStart outside IDLE is ignored.

## Configuration
- NFC_DATAIN_WATCHDOG_EN:
  - defined: a counter runs in WAIT, resets on each iDQValid, and reaching WatchdogCycles sets oTimeout (sticky until next start or reset) and forces POSTAMBLE;
  - undefined: WAIT waits indefinitely and oTimeout=0.

## Test plan
- Length 8, iDQValid 3 clocks after each toggle, iReadReady=1 → 8 toggles at 4'b0101, words 0x11111111..0x88888888 out in order, CE=2'b11 on the selected way only, one oLastStep.
- Length 40, FifoDepth 16, iReadReady=0 → exactly 16 toggles then RE=1111 pauses; raising iReadReady resumes, all 40 words delivered, no drop.
- Length 0 → no CE, no toggles, oLastStep one clock after start.
- Reset asserted mid-TOGGLE at word 5 of 20 → next clock CE=0, RE=1111, oReadValid=0, oReady=1.
- With macro: length 4, only 3 iDQValid → after 255 idle clocks oTimeout=1, postamble, oLastStep after FIFO drains.
- iStart pulsed during TOGGLE → ignored; latched length unchanged.
